// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   ALU_ADD / ALU_SUB : values of the 'sub' mode input
//   DATA_WIDTH        : default datapath width
//   carry0()          : carry injected into the lowest chunk for a given mode
package pipelined_add_sub_pkg;

  localparam logic ALU_ADD    = 1'b0;
  localparam logic ALU_SUB    = 1'b1;
  localparam int   DATA_WIDTH = 32;

  // Subtraction is A + ~B + 1 - borrow, so the injected carry is the
  // inverted borrow-in; addition passes the carry-in straight through.
  function automatic logic carry0(input logic sub, input logic cin);
    logic c_v;
    if (sub == ALU_SUB) begin
      c_v = ~cin;
    end else begin
      c_v = cin;
    end
    return c_v;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_adder_chunk.sv
// adder_chunk: combinational N-bit ripple-carry full-adder chain.
// Ports:
//   a, b   : N-bit addends
//   cin    : carry into bit 0
//   sum    : N-bit sum
//   cout   : carry out of bit N-1
//   c_msb  : carry into bit N-1 (used for signed overflow)
module adder_chunk #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  // Ripple the carry bit by bit; c_msb captures the carry just before the top bit.
  always_comb begin
    logic carry_v;
    carry_v = cin;
    c_msb   = cin;
    sum     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      c_msb   = carry_v;
      sum[i]  = a[i] ^ b[i] ^ carry_v;
      carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
    end
    cout = carry_v;
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit adder/subtractor split into STAGES registered
// chunks of WIDTH/STAGES bits, with valid/ready handshake on both sides.
// Ports:
//   clk, reset           : rising-edge clock, async active-high reset
//   in_valid / in_ready  : operand beat handshake (a, b, sub, cin)
//   sub                  : 0 = a+b+cin, 1 = a-b-cin
//   out_valid / out_ready: result beat handshake
//   sum, cout            : result mod 2^WIDTH and raw carry out (sub: 1 = no borrow)
//   overflow, zero       : signed overflow and sum == 0
// Stage k consumes operand bits [k*CHUNK +: CHUNK]. Each stage register keeps
// only the result bits finished so far (done_r) and the operand bits still to
// be consumed (pa_r/pb_r), so both vectors shift one chunk per stage.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = DATA_WIDTH,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int PW = WIDTH - k * CHUNK;  // operand bits entering this stage
    localparam int DW = (k + 1) * CHUNK;    // result bits complete after this stage

    logic             src_v_s;
    logic             src_c_s;
    logic [PW-1:0]    src_pa_s;
    logic [PW-1:0]    src_pb_s;
    logic [DW-1:0]    nxt_done_s;
    logic             rdy_s;
    logic             down_rdy_s;
    logic [CHUNK-1:0] ch_sum_s;
    logic             ch_cout_s;
    logic             ch_msb_s;
    logic             v_r;
    logic             c_r;
    logic [DW-1:0]    done_r;

    if (k == 0) begin : g_src
      assign src_v_s    = in_valid;
      assign src_c_s    = carry0(sub, cin);
      assign src_pa_s   = a;
      assign src_pb_s   = (sub == ALU_SUB) ? ~b : b;
      assign nxt_done_s = ch_sum_s;
    end else begin : g_src
      assign src_v_s    = g_stage[k-1].v_r;
      assign src_c_s    = g_stage[k-1].c_r;
      assign src_pa_s   = g_stage[k-1].g_pend.pa_r;
      assign src_pb_s   = g_stage[k-1].g_pend.pb_r;
      assign nxt_done_s = {ch_sum_s, g_stage[k-1].done_r};
    end

    if (k == STAGES - 1) begin : g_down
      assign down_rdy_s = out_ready;
    end else begin : g_down
      assign down_rdy_s = g_stage[k+1].rdy_s;
    end

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign rdy_s = ~v_r | down_rdy_s;

    adder_chunk #(.N(CHUNK)) u_chunk (
      .a     (src_pa_s[CHUNK-1:0]),
      .b     (src_pb_s[CHUNK-1:0]),
      .cin   (src_c_s),
      .sum   (ch_sum_s),
      .cout  (ch_cout_s),
      .c_msb (ch_msb_s)
    );

    // Stage valid/carry/result: load when ready, hold contents under backpressure.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_r    <= 1'b0;
        c_r    <= 1'b0;
        done_r <= {DW{1'b0}};
      end else if (rdy_s) begin
        v_r <= src_v_s;
        if (src_v_s) begin
          c_r    <= ch_cout_s;
          done_r <= nxt_done_s;
        end
      end
    end

    if (k < STAGES - 1) begin : g_pend
      logic [PW-CHUNK-1:0] pa_r;
      logic [PW-CHUNK-1:0] pb_r;
      logic                msb_unused_s;

      // Carry into a chunk MSB only matters for the top chunk.
      assign msb_unused_s = ch_msb_s;

      // Pending operand bits: drop the chunk just consumed.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pa_r <= {(PW-CHUNK){1'b0}};
          pb_r <= {(PW-CHUNK){1'b0}};
        end else if (rdy_s && src_v_s) begin
          pa_r <= src_pa_s[PW-1:CHUNK];
          pb_r <= src_pb_s[PW-1:CHUNK];
        end
      end
    end else begin : g_flags
      logic ovf_r;
      logic zero_r;

      // Final-stage flags, registered alongside the completed sum.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (rdy_s && src_v_s) begin
          ovf_r  <= ch_msb_s ^ ch_cout_s;
          zero_r <= ~|nxt_done_s;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy_s;
  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].done_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign overflow  = g_stage[STAGES-1].g_flags.ovf_r;
  assign zero      = g_stage[STAGES-1].g_flags.zero_r;

endmodule
